hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 16-bit five-stage CPU (IF, ID, EX, MEM, WB). It tracks the destination registers of in-flight instructions and produces the registered operand-select codes for the execute stage's two ALU input multiplexers. It also generates load-use stalls and flushes on a taken branch. It sits beside the ID/EX pipeline register and drives the EX-stage select inputs alongside the control FSM.

## Interface
- RA_W, 3, register-address width (8 architectural registers, r0 hardwired zero)
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  RA_W  ID source register addresses
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- id_use_imm  in  1  ALU input 2 takes the extended immediate
- id_rd  in  RA_W  ID destination register
- id_writes_rd  in  1  instruction writes the register file
- id_is_load  in  1  instruction is a data-memory load
- ex_branch_taken  in  1  branch in EX resolved taken (from alu_zero logic)
- stall  out  1  hold PC and IF/ID, insert a bubble into ID/EX
- flush  out  1  squash IF/ID and ID/EX contents
- mux_alu_in1_select  out  2  EX select, ALU input 1
- mux_alu_in2_select  out  2  EX select, ALU input 2

## Operation
- Select codes:
  - SEL_REG=0: rf_rd1 on in1, rf_rd2 on in2
  - SEL_ALT=1: ext_imm on in2; never produced on in1
  - SEL_BYP_ALU=2: bypass_from_alu (producer now in MEM)
  - SEL_BYP_DM=3: bypass_from_dm (producer now in WB)
- Tracking registers:
  - EX slot: valid, rd, we, load.
  - MEM slot: valid, rd, we. Shifted from the EX slot each cycle.
- Register file is write-through. A WB write is visible to the same-cycle ID read, so no third bypass level is needed.
- match_X(r) is defined as: X.valid & X.we & X.rd==r & r!=0.
- Load-use stall:
  - Asserted when id_valid and match_EX(src) with EX.load, for any used source.
  - For in2, the source counts only when !id_use_imm.
- Forward selection is computed in ID and registered into EX when ID advances.
  - in1: match_EX(rs1) → BYP_ALU; else match_MEM(rs1) → BYP_DM; else REG.
  - in2: id_use_imm → ALT; else the same priority on rs2.
  - The youngest producer (EX) wins.
- When stall is asserted:
  - EX slot loads a bubble (valid=0).
  - Registered selects load REG.
  - The MEM slot still advances.
- When flush is asserted:
  - EX slot loads a bubble.
  - Selects load REG.
  - Flush dominates stall, so stall is forced low in that cycle.

## Timing
- stall and flush are combinational from the inputs and tracking state, in the same cycle.
- Selects are registered. They are valid during the cycle the instruction occupies EX, one clock after its ID cycle.
- Reset (synchronous):
  - All valid bits cleared.
  - Both selects = 0.
  - stall = 0 in the next cycle.
  - flush follows ex_branch_taken.
- Load-use adds exactly one bubble. The consumer then reaches EX with BYP_DM.
- A back-to-back ALU dependency costs 0 cycles (BYP_ALU).
- A dependency at distance 2 costs 0 cycles (BYP_DM).
- A dependency at distance 3 or more reads the register file (REG).
- Reset asserted mid-stall clears everything; no stall is asserted in the cycle after.

## Configuration
- HAZARD_FORWARDING_EN defined: forwarding operates as specified above.
- HAZARD_FORWARDING_EN undefined:
  - Selects are only REG or ALT.
  - stall is asserted while any used source matches the EX or MEM slot, whether or not the producer is a load.
  - Worst-case penalty is 2 cycles.
  - Flush behaviour is unchanged.

## Structure
- Shared package cpu_pkg holds:
  - the select-code constants SEL_REG, SEL_ALT, SEL_BYP_ALU, SEL_BYP_DM;
  - RA_W;
  - a typedef for the tracking slot {valid, rd, we, load}.
- One sub-module, hazard_fwd_sel, is natural: a combinational priority selector instantiated once per ALU input.

## Test plan
- add r1; then add r2,r1,r3 → stall=0; next cycle in1_select=2.
- add r1; nop; sub r4,r3,r1 → stall=0; in2_select=3 when sub reaches EX.
- lw r2; add r5,r2,r2 → stall=1 for exactly one cycle, then in1_select=3 and in2_select=3.
- Instruction writing r0 followed by a reader of r0 → no stall, selects=0.
- ex_branch_taken=1 concurrent with a load-use condition → flush=1, stall=0; next EX slot is a bubble with selects=0.
- Without HAZARD_FORWARDING_EN: add r1; add r2,r1,r1 → stall high for 2 cycles, selects=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-address width, ALU operand select
// codes and the hazard tracking slot with its match helper.
package cpu_pkg;

   localparam int RA_W = 3;

   typedef logic [RA_W-1:0] reg_addr_t;
   typedef logic [1:0]      sel_t;

   localparam sel_t SEL_REG     = 2'd0;
   localparam sel_t SEL_ALT     = 2'd1;
   localparam sel_t SEL_BYP_ALU = 2'd2;
   localparam sel_t SEL_BYP_DM  = 2'd3;

   typedef struct packed {
      logic      valid;
      reg_addr_t rd;
      logic      we;
      logic      load;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '0;

   // r0 is hardwired zero, so it never carries a dependency
   function automatic logic slot_match(slot_t s, reg_addr_t r);
      return s.valid & s.we & (s.rd == r) & (r != '0);
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// ID-side bundle between the decode stage and the hazard unit.
// master: decode/control side; slave: hazard_unit.
interface hazard_unit_if;
   import cpu_pkg::*;

   logic      id_valid;
   reg_addr_t id_rs1;
   reg_addr_t id_rs2;
   logic      id_uses_rs1;
   logic      id_uses_rs2;
   logic      id_use_imm;
   reg_addr_t id_rd;
   logic      id_writes_rd;
   logic      id_is_load;
   logic      ex_branch_taken;
   logic      stall;
   logic      flush;
   sel_t      mux_alu_in1_select;
   sel_t      mux_alu_in2_select;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
      output id_use_imm, id_rd, id_writes_rd, id_is_load,
      output ex_branch_taken,
      input  stall, flush, mux_alu_in1_select, mux_alu_in2_select
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
      input  id_use_imm, id_rd, id_writes_rd, id_is_load,
      input  ex_branch_taken,
      output stall, flush, mux_alu_in1_select, mux_alu_in2_select
   );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Per-operand priority selector: picks the ALU input source and flags
// a stall request. Forwarding enabled by macro HAZARD_FORWARDING_EN.
// Ports: src/use_src/use_alt from ID, ex_slot/mem_slot tracking,
// sel (operand select), hazard (this operand must wait).
module hazard_fwd_sel
   import cpu_pkg::*;
(
   input  reg_addr_t src,
   input  logic      use_src,
   input  logic      use_alt,
   input  slot_t     ex_slot,
   input  slot_t     mem_slot,
   output sel_t      sel,
   output logic      hazard
);

   logic ex_hit;
   logic mem_hit;
   logic unused_load;

   assign ex_hit      = slot_match(ex_slot, src);
   assign mem_hit     = slot_match(mem_slot, src);
   assign unused_load = ex_slot.load ^ mem_slot.load;

`ifdef HAZARD_FORWARDING_EN
   // only a load still in EX has no data ready in time to bypass
   assign hazard = use_src & ex_hit & ex_slot.load;

   // the youngest producer holds the newest value
   always_comb begin
      sel = SEL_REG;
      if (use_alt)
         sel = SEL_ALT;
      else if (ex_hit)
         sel = SEL_BYP_ALU;
      else if (mem_hit)
         sel = SEL_BYP_DM;
   end
`else
   // no bypass paths: wait until the producer reaches WB
   assign hazard = use_src & (ex_hit | mem_hit);
   assign sel    = use_alt ? SEL_ALT : SEL_REG;
`endif

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use/RAW stalls, branch flush and
// registered EX operand selects. Option macro: HAZARD_FORWARDING_EN.
// Ports: clock, reset (sync, active-high), hz (hazard_unit_if.slave).
module hazard_unit
   import cpu_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   hazard_unit_if.slave  hz
);

   slot_t ex_q;
   slot_t mem_q;
   slot_t id_slot;
   sel_t  sel1_q;
   sel_t  sel2_q;
   sel_t  sel1_d;
   sel_t  sel2_d;
   logic  haz1;
   logic  haz2;
   logic  stall_w;
   logic  flush_w;
   logic  hold;

   assign id_slot = '{
      valid: hz.id_valid,
      rd:    hz.id_rd,
      we:    hz.id_writes_rd,
      load:  hz.id_is_load
   };

   hazard_fwd_sel u_sel1 (
      .src      (hz.id_rs1),
      .use_src  (hz.id_uses_rs1),
      .use_alt  (1'b0),
      .ex_slot  (ex_q),
      .mem_slot (mem_q),
      .sel      (sel1_d),
      .hazard   (haz1)
   );

   // an immediate operand hides rs2 from the stall check
   hazard_fwd_sel u_sel2 (
      .src      (hz.id_rs2),
      .use_src  (hz.id_uses_rs2 & ~hz.id_use_imm),
      .use_alt  (hz.id_use_imm),
      .ex_slot  (ex_q),
      .mem_slot (mem_q),
      .sel      (sel2_d),
      .hazard   (haz2)
   );

   // flush squashes the stalled instruction anyway, so it wins
   assign flush_w = hz.ex_branch_taken;
   assign stall_w = hz.id_valid & (haz1 | haz2) & ~flush_w;
   assign hold    = stall_w | flush_w;

   always_ff @(posedge clock) begin
      if (reset) begin
         ex_q   <= SLOT_EMPTY;
         mem_q  <= SLOT_EMPTY;
         sel1_q <= SEL_REG;
         sel2_q <= SEL_REG;
      end else begin
         mem_q  <= ex_q;
         ex_q   <= hold ? SLOT_EMPTY : id_slot;
         sel1_q <= hold ? SEL_REG : sel1_d;
         sel2_q <= hold ? SEL_REG : sel2_d;
      end
   end

   assign hz.stall              = stall_w;
   assign hz.flush              = flush_w;
   assign hz.mux_alu_in1_select = sel1_q;
   assign hz.mux_alu_in2_select = sel2_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: per-cycle vector table plus reset
// sequences; expectations follow HAZARD_FORWARDING_EN when defined.
module tb_hazard_unit;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   hazard_unit_if hz_if ();

   hazard_unit dut (
      .clock (clk),
      .reset (rst),
      .hz    (hz_if)
   );

   typedef struct {
      logic      v;
      reg_addr_t rs1;
      reg_addr_t rs2;
      logic      u1;
      logic      u2;
      logic      imm;
      reg_addr_t rd;
      logic      wr;
      logic      ld;
      logic      br;
      logic      st;
      logic      fl;
      sel_t      s1;
      sel_t      s2;
   } vec_t;

   vec_t tv[$];
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [3:0] act,
                        input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(int v, int rs1, int rs2, int u1, int u2,
                               int imm, int rd, int wr, int ld, int br,
                               int st, int s1, int s2);
      vec_t r;
      r.v   = 1'(v);
      r.rs1 = reg_addr_t'(rs1);
      r.rs2 = reg_addr_t'(rs2);
      r.u1  = 1'(u1);
      r.u2  = 1'(u2);
      r.imm = 1'(imm);
      r.rd  = reg_addr_t'(rd);
      r.wr  = 1'(wr);
      r.ld  = 1'(ld);
      r.br  = 1'(br);
      r.st  = 1'(st);
      r.fl  = 1'(br);
      r.s1  = sel_t'(s1);
      r.s2  = sel_t'(s2);
      return r;
   endfunction

   function automatic vec_t alu(int rd, int rs1, int rs2, int br,
                                int st, int s1, int s2);
      return mk(1, rs1, rs2, 1, 1, 0, rd, 1, 0, br, st, s1, s2);
   endfunction

   function automatic vec_t lw(int rd, int s1, int s2);
      return mk(1, 0, 0, 1, 0, 1, rd, 1, 1, 0, 0, s1, s2);
   endfunction

   function automatic vec_t nop(int s1, int s2);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s1, s2);
   endfunction

   // store-like: reads r0, names rd=3 but does not write it
   function automatic vec_t st3(int s1, int s2);
      return mk(1, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0, s1, s2);
   endfunction

   // addi r5, r0, imm with rs2 field = r2 (ignored, immediate used)
   function automatic vec_t addi(int s1, int s2);
      return mk(1, 0, 2, 1, 1, 1, 5, 1, 0, 0, 0, s1, s2);
   endfunction

   task automatic drive(input vec_t r);
      hz_if.id_valid        = r.v;
      hz_if.id_rs1          = r.rs1;
      hz_if.id_rs2          = r.rs2;
      hz_if.id_uses_rs1     = r.u1;
      hz_if.id_uses_rs2     = r.u2;
      hz_if.id_use_imm      = r.imm;
      hz_if.id_rd           = r.rd;
      hz_if.id_writes_rd    = r.wr;
      hz_if.id_is_load      = r.ld;
      hz_if.ex_branch_taken = r.br;
   endtask

   initial begin
      rst = 1'b1;
      drive(nop(0, 0));
      hz_if.ex_branch_taken = 1'b1;
      @(negedge clk);
      #1;
      check("reset flush follows branch", 4'(hz_if.flush), 4'd1);
      hz_if.ex_branch_taken = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset stall", 4'(hz_if.stall), 4'd0);
      check("reset flush", 4'(hz_if.flush), 4'd0);
      check("reset sel1", 4'(hz_if.mux_alu_in1_select), 4'd0);
      check("reset sel2", 4'(hz_if.mux_alu_in2_select), 4'd0);

`ifdef HAZARD_FORWARDING_EN
      tv.push_back(alu(1, 2, 3, 0, 0, 0, 0));
      tv.push_back(alu(2, 1, 3, 0, 0, 0, 0));
      tv.push_back(nop(2, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(alu(1, 5, 6, 0, 0, 0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(alu(4, 3, 1, 0, 0, 0, 0));
      tv.push_back(nop(0, 3));
      tv.push_back(nop(0, 0));
      tv.push_back(lw(2, 0, 0));
      tv.push_back(alu(5, 2, 2, 0, 1, 0, 1));
      tv.push_back(alu(5, 2, 2, 0, 0, 0, 0));
      tv.push_back(nop(3, 3));
      tv.push_back(nop(0, 0));
      tv.push_back(lw(0, 0, 0));
      tv.push_back(alu(3, 0, 0, 0, 0, 0, 1));
      tv.push_back(nop(0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(lw(2, 0, 0));
      tv.push_back(alu(5, 2, 2, 1, 0, 0, 1));
      tv.push_back(alu(6, 5, 5, 0, 0, 0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(alu(1, 4, 4, 0, 0, 0, 0));
      tv.push_back(alu(1, 4, 4, 0, 0, 0, 0));
      tv.push_back(alu(7, 1, 1, 0, 0, 0, 0));
      tv.push_back(nop(2, 2));
      tv.push_back(st3(0, 0));
      tv.push_back(alu(1, 3, 3, 0, 0, 0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(lw(2, 0, 0));
      tv.push_back(addi(0, 1));
      tv.push_back(nop(0, 1));
      tv.push_back(nop(0, 0));
`else
      tv.push_back(alu(1, 2, 3, 0, 0, 0, 0));
      tv.push_back(alu(2, 1, 3, 0, 1, 0, 0));
      tv.push_back(alu(2, 1, 3, 0, 1, 0, 0));
      tv.push_back(alu(2, 1, 3, 0, 0, 0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(alu(1, 5, 6, 0, 0, 0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(alu(4, 3, 1, 0, 1, 0, 0));
      tv.push_back(alu(4, 3, 1, 0, 0, 0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(lw(2, 0, 0));
      tv.push_back(alu(5, 2, 2, 0, 1, 0, 1));
      tv.push_back(alu(5, 2, 2, 0, 1, 0, 0));
      tv.push_back(alu(5, 2, 2, 0, 0, 0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(lw(0, 0, 0));
      tv.push_back(alu(3, 0, 0, 0, 0, 0, 1));
      tv.push_back(nop(0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(lw(2, 0, 0));
      tv.push_back(alu(5, 2, 2, 1, 0, 0, 1));
      tv.push_back(alu(6, 5, 5, 0, 0, 0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(st3(0, 0));
      tv.push_back(alu(1, 3, 3, 0, 0, 0, 0));
      tv.push_back(nop(0, 0));
      tv.push_back(lw(2, 0, 0));
      tv.push_back(addi(0, 1));
      tv.push_back(nop(0, 1));
      tv.push_back(nop(0, 0));
`endif

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         drive(tv[i]);
         #1;
         check($sformatf("row%0d stall", i),
               4'(hz_if.stall), 4'(tv[i].st));
         check($sformatf("row%0d flush", i),
               4'(hz_if.flush), 4'(tv[i].fl));
         check($sformatf("row%0d sel1", i),
               4'(hz_if.mux_alu_in1_select), 4'(tv[i].s1));
         check($sformatf("row%0d sel2", i),
               4'(hz_if.mux_alu_in2_select), 4'(tv[i].s2));
      end

      // reset asserted while a load-use stall is active
      @(negedge clk);
      drive(lw(2, 0, 0));
      #1;
      check("midrst lw stall", 4'(hz_if.stall), 4'd0);
      @(negedge clk);
      drive(alu(5, 2, 2, 0, 0, 0, 0));
      rst = 1'b1;
      #1;
      check("midrst stall before reset", 4'(hz_if.stall), 4'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst stall after reset", 4'(hz_if.stall), 4'd0);
      check("midrst sel1 after reset",
            4'(hz_if.mux_alu_in1_select), 4'd0);
      check("midrst sel2 after reset",
            4'(hz_if.mux_alu_in2_select), 4'd0);
      @(negedge clk);
      drive(nop(0, 0));
      #1;
      check("midrst consumer sel1",
            4'(hz_if.mux_alu_in1_select), 4'd0);
      check("midrst consumer sel2",
            4'(hz_if.mux_alu_in2_select), 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
